rom_shadow_copier: RTL

Bus-initiator engine that drives the ROM's chip-select/output-enable read interface and copies the ROM image, byte by byte, into system RAM, so the 6502 can later run its monitor/BASIC from faster, writable RAM. It sits between the ROM, the RAM write port and the CPU reset line. It holds the CPU in reset until the copy completes, then releases it.

---
 rtl/rom_shadow_copier_if.sv | 26 ++
 rtl/rom_shadow_copier.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rom_shadow_copier_if.sv
// ROM read port and RAM write port seen by the shadow copier.
// master = copier side, slave = memory side.
interface rom_shadow_copier_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ROM_A;
    logic [DATA_WIDTH-1:0] ROM_DI;
    logic                  ROM_CS_N;
    logic                  ROM_OE_N;
    logic [15:0]           RAM_A;
    logic [DATA_WIDTH-1:0] RAM_DO;
    logic                  RAM_CS_N;
    logic                  RAM_WE_N;
    logic                  RAM_WAIT;

    modport master (
        output ROM_A, ROM_CS_N, ROM_OE_N, RAM_A, RAM_DO, RAM_CS_N, RAM_WE_N,
        input  ROM_DI, RAM_WAIT
    );

    modport slave (
        input  ROM_A, ROM_CS_N, ROM_OE_N, RAM_A, RAM_DO, RAM_CS_N, RAM_WE_N,
        output ROM_DI, RAM_WAIT
    );
endinterface

// File: rtl/rom_shadow_copier.sv
// Streams ROM[0..LENGTH-1] into RAM at DST_BASE, holding the CPU in reset until the first copy ends.
// Define ROM_COPY_CHECKSUM_EN to get a running byte sum of accepted writes on CHECKSUM.
module rom_shadow_copier #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DATA_WIDTH = 8,
    parameter int          LENGTH     = 1 << ADDR_WIDTH,
    parameter logic [15:0] DST_BASE   = 16'hC000,
    parameter bit          AUTOSTART  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  CPU_RES_N,
    output logic [DATA_WIDTH-1:0] CHECKSUM,
    rom_shadow_copier_if.master   bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, FINISH} state_t;

    state_t                state, state_nxt;
    logic                  arm_q;
    logic                  read_active;
    logic [ADDR_WIDTH-1:0] rom_a;
    logic [ADDR_WIDTH-1:0] ld_cnt;
    logic [15:0]           off16;
    logic [15:0]           ram_a;
    logic [DATA_WIDTH-1:0] ram_do;
    logic                  ram_cs_n;
    logic                  ram_we_n;
    logic                  done_q;
    logic                  cpu_res_n_q;
    logic                  stall;
    logic                  start_go;
    logic                  last_ld;

    // A RAM stall freezes the whole pipeline, including the ROM read.
    assign stall    = bus.RAM_WAIT;
    assign start_go = ((state == IDLE) || (state == FINISH)) && (START || arm_q);
    assign last_ld  = (ld_cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = PRIME;
            PRIME:   if (!stall) state_nxt = STREAM;
            STREAM:  if (!stall && last_ld) state_nxt = FLUSH;
            FLUSH:   if (!stall) state_nxt = FINISH;
            FINISH:  state_nxt = start_go ? PRIME : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY         = (state == PRIME) || (state == STREAM) || (state == FLUSH);
        bus.ROM_CS_N = ~(read_active & ~stall);
        bus.ROM_OE_N = ~(read_active & ~stall);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            arm_q       <= AUTOSTART;
            read_active <= 1'b0;
            rom_a       <= '0;
            ld_cnt      <= '0;
            off16       <= '0;
            ram_a       <= DST_BASE;
            ram_do      <= '0;
            ram_cs_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            done_q      <= 1'b0;
            cpu_res_n_q <= 1'b0;
        end else begin
            arm_q <= 1'b0;
            if (start_go) begin
                read_active <= 1'b1;
                rom_a       <= '0;
                ld_cnt      <= '0;
                off16       <= '0;
                done_q      <= 1'b0;
            end else if (!stall) begin
                // The ROM latches the current address on this edge; stop reading once the last one is in.
                if (read_active) begin
                    if (rom_a == LAST) read_active <= 1'b0;
                    else               rom_a       <= rom_a + ONE;
                end
                if (state == STREAM) begin
                    ram_do   <= bus.ROM_DI;
                    ram_a    <= DST_BASE + off16;
                    off16    <= off16 + 16'd1;
                    ld_cnt   <= ld_cnt + ONE;
                    ram_cs_n <= 1'b0;
                    ram_we_n <= 1'b0;
                end
                if (state == FLUSH) begin
                    ram_cs_n    <= 1'b1;
                    ram_we_n    <= 1'b1;
                    done_q      <= 1'b1;
                    cpu_res_n_q <= 1'b1;
                end
            end
        end
    end

`ifdef ROM_COPY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;

    always_ff @(posedge CLK) begin
        if (RESET)                       csum <= '0;
        else if (start_go)               csum <= '0;
        else if (!ram_we_n && !stall)    csum <= csum + ram_do;
    end

    assign CHECKSUM = csum;
`else
    assign CHECKSUM = '0;
`endif

    assign DONE         = done_q;
    assign CPU_RES_N    = cpu_res_n_q;
    assign bus.ROM_A    = rom_a;
    assign bus.RAM_A    = ram_a;
    assign bus.RAM_DO   = ram_do;
    assign bus.RAM_CS_N = ram_cs_n;
    assign bus.RAM_WE_N = ram_we_n;
endmodule
